// File: rtl/multiplier_pkg.sv
// Shared width helpers, mode encoding and parameter legality checks for the SIMD MAC pipeline.
// Pure constants/functions; no logic, no latency, no flow control.
package multiplier_pkg;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_HALF = 1'b1;

  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 6;

  function automatic int lane_w(input int h, input int g);
    return 2 * h + g;
  endfunction

  function automatic int acc_w(input int h, input int g);
    return 4 * h + 2 * g;
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/multiplier_simd_acc_pipe_if.sv
// Operand/control bus into the SIMD MAC and accumulator result out of it.
// Valid-only: the consumer never stalls the producer.
interface multiplier_simd_acc_pipe_if #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int C_W = 44
);
  logic           in_valid;
  logic [A_W-1:0] A;
  logic [B_W-1:0] B;
  logic           A_sign;
  logic           B_sign;
  logic           HALF_0;
  logic           acc_en;
  logic           out_valid;
  logic [C_W-1:0] C;

  modport master (
    output in_valid, A, B, A_sign, B_sign, HALF_0, acc_en,
    input  out_valid, C
  );

  modport slave (
    input  in_valid, A, B, A_sign, B_sign, HALF_0, acc_en,
    output out_valid, C
  );
endinterface

// File: rtl/mult_chop_pp.sv
// Signed (H+1)x(H+1) partial product; each H-bit chop is extended by msb & sign.
// Combinational, no handshake.
module mult_chop_pp #(
  parameter int H = 9
) (
  input  logic [H-1:0]        a,
  input  logic [H-1:0]        b,
  input  logic                a_sign,
  input  logic                b_sign,
  output logic signed [2*H+1:0] p
);
  logic signed [H:0] a_x;
  logic signed [H:0] b_x;

  assign a_x = {a[H-1] & a_sign, a};
  assign b_x = {b[H-1] & b_sign, b};
  assign p   = a_x * b_x;
endmodule

// File: rtl/multiplier_simd_acc_pipe.sv
// Precision-configurable MAC: one full-width or two half-width lane products, loaded or accumulated into C.
// in_valid -> out_valid in LATENCY cycles, one op per cycle, no backpressure.
module multiplier_simd_acc_pipe
  import multiplier_pkg::*;
#(
  parameter int A_chop_size = 18,
  parameter int B_chop_size = 18,
  parameter int ACC_GUARD   = 4,
  parameter int LATENCY     = 3
) (
  input logic clk,
  input logic reset,
  multiplier_simd_acc_pipe_if.slave bus
);
  localparam int H    = A_chop_size / 2;
  localparam int G    = ACC_GUARD;
  localparam int LW   = lane_w(H, G);
  localparam int CW   = acc_w(H, G);
  localparam int PPW  = 2 * H + 2;
  localparam int NRET = LATENCY - 2;

  // Lane extension needs room for the full (H+1)x(H+1) product.
  if (!latency_ok(LATENCY) || (A_chop_size != B_chop_size) ||
      (A_chop_size % 2 != 0) || (ACC_GUARD < 2)) begin : g_param_err
    $error("multiplier_simd_acc_pipe: illegal parameter set");
  end

  typedef struct packed {
    logic           vld;
    logic           half;
    logic           acc;
    logic [PPW-1:0] ll;
    logic [PPW-1:0] lh;
    logic [PPW-1:0] hl;
    logic [PPW-1:0] hh;
  } pp_stage_t;

  logic           s1_vld;
  logic [2*H-1:0] s1_a;
  logic [2*H-1:0] s1_b;
  logic           s1_as;
  logic           s1_bs;
  logic           s1_half;
  logic           s1_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_as   <= 1'b0;
      s1_bs   <= 1'b0;
      s1_half <= MODE_FULL;
      s1_acc  <= 1'b0;
    end else begin
      s1_vld  <= bus.in_valid;
      s1_a    <= bus.A;
      s1_b    <= bus.B;
      s1_as   <= bus.A_sign;
      s1_bs   <= bus.B_sign;
      s1_half <= bus.HALF_0;
      s1_acc  <= bus.acc_en;
    end
  end

  // Lower chops are unsigned in full mode but carry the lane-0 signs in half mode.
  logic signed [PPW-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  mult_chop_pp #(.H(H)) u_pp_ll (
    .a(s1_a[H-1:0]), .b(s1_b[H-1:0]),
    .a_sign(s1_half & s1_as), .b_sign(s1_half & s1_bs), .p(pp_ll)
  );
  mult_chop_pp #(.H(H)) u_pp_lh (
    .a(s1_a[H-1:0]), .b(s1_b[2*H-1:H]),
    .a_sign(1'b0), .b_sign(s1_bs), .p(pp_lh)
  );
  mult_chop_pp #(.H(H)) u_pp_hl (
    .a(s1_a[2*H-1:H]), .b(s1_b[H-1:0]),
    .a_sign(s1_as), .b_sign(1'b0), .p(pp_hl)
  );
  mult_chop_pp #(.H(H)) u_pp_hh (
    .a(s1_a[2*H-1:H]), .b(s1_b[2*H-1:H]),
    .a_sign(s1_as), .b_sign(s1_bs), .p(pp_hh)
  );

  pp_stage_t st_in;
  pp_stage_t st_out;

  always_comb begin
    st_in      = '0;
    st_in.vld  = s1_vld;
    st_in.half = s1_half;
    st_in.acc  = s1_acc;
    st_in.ll   = pp_ll;
    st_in.hh   = pp_hh;
    st_in.lh   = s1_half ? '0 : pp_lh;
    st_in.hl   = s1_half ? '0 : pp_hl;
  end

  if (NRET == 0) begin : g_no_retime
    assign st_out = st_in;
  end else begin : g_retime
    pp_stage_t pipe [NRET];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < NRET; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= st_in;
        for (int i = 1; i < NRET; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign st_out = pipe[NRET-1];
  end

  logic [CW-1:0] c_q;
  logic          c_mode;
  logic          ov_q;
  logic [CW-1:0] ll_x, lh_x, hl_x, hh_x, full_p;
  logic [LW-1:0] lane0_p, lane1_p, lane0_n, lane1_n;
  logic [CW-1:0] c_nxt;
  logic          do_acc;

  always_comb begin
    ll_x    = CW'($signed(st_out.ll));
    lh_x    = CW'($signed(st_out.lh));
    hl_x    = CW'($signed(st_out.hl));
    hh_x    = CW'($signed(st_out.hh));
    full_p  = (hh_x << (2 * H)) + (lh_x << H) + (hl_x << H) + ll_x;
    lane0_p = LW'($signed(st_out.ll));
    lane1_p = LW'($signed(st_out.hh));
    // Accumulating onto a C formed in the other mode is meaningless, so it reloads instead.
    do_acc  = st_out.acc && (st_out.half == c_mode);
    lane0_n = do_acc ? c_q[LW-1:0] + lane0_p : lane0_p;
    lane1_n = do_acc ? c_q[CW-1:LW] + lane1_p : lane1_p;
    if (st_out.half == MODE_HALF) begin
      c_nxt = {lane1_n, lane0_n};
    end else begin
      c_nxt = do_acc ? c_q + full_p : full_p;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q    <= '0;
      c_mode <= MODE_FULL;
      ov_q   <= 1'b0;
    end else begin
      ov_q <= st_out.vld;
      if (st_out.vld) begin
        c_q    <= c_nxt;
        c_mode <= st_out.half;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.C         = c_q;
endmodule
